// File: rtl/ahbl_to_apb_bridge.sv
// rtl/ahbl_to_apb_bridge.sv - AHB-Lite slave to APB master bridge, one APB SETUP/ACCESS per AHB transfer.
// Optional macro APB_BRIDGE_SLVERR_EN: pslverr produces the two-cycle AHB ERROR response.
module ahbl_to_apb_bridge #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst_n_sync,
  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,
  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_RESP, S_ERR1, S_ERR2
  } state_t;

  state_t state_q, state_d;

  logic               psel_q, penable_q, pwrite_q, hready_resp_q, hresp_q;
  logic [W_PADDR-1:0] paddr_q;
  logic [W_DATA-1:0]  pwdata_q, hrdata_q;
  logic               can_accept, take, slverr;
  logic               unused_inputs;

  assign unused_inputs = ^{ahbls_hsize, ahbls_haddr[W_HADDR-1:W_PADDR], ahbls_htrans[0], apbm_pslverr};

`ifdef APB_BRIDGE_SLVERR_EN
  assign slverr = apbm_pslverr;
`else
  assign slverr = 1'b0;
`endif

  // Only the slots where this slave drives hready_resp high can start a new transfer.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_RESP) || (state_q == S_ERR2);
  assign take       = can_accept && ahbls_hready && ahbls_htrans[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP, S_ERR2: state_d = take ? (ahbls_hwrite ? S_WDATA : S_SETUP) : S_IDLE;
      S_WDATA:                state_d = S_SETUP;
      S_SETUP:                state_d = S_ACCESS;
      S_ACCESS:               if (apbm_pready) state_d = slverr ? S_ERR1 : S_RESP;
      S_ERR1:                 state_d = S_ERR2;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q       <= S_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      hrdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= (state_d == S_SETUP) || (state_d == S_ACCESS);
      penable_q     <= (state_d == S_ACCESS);
      hready_resp_q <= (state_d == S_IDLE) || (state_d == S_RESP) || (state_d == S_ERR2);
      hresp_q       <= (state_d == S_ERR1) || (state_d == S_ERR2);
      if (take) begin
        paddr_q  <= ahbls_haddr[W_PADDR-1:0];
        pwrite_q <= ahbls_hwrite;
      end
      if (state_q == S_WDATA) pwdata_q <= ahbls_hwdata;
      if ((state_q == S_ACCESS) && apbm_pready && !pwrite_q) hrdata_q <= apbm_prdata;
    end
  end

  assign ahbls_hready_resp = hready_resp_q;
  assign ahbls_hresp       = hresp_q;
  assign ahbls_hrdata      = hrdata_q;
  assign apbm_paddr        = paddr_q;
  assign apbm_psel         = psel_q;
  assign apbm_penable      = penable_q;
  assign apbm_pwrite       = pwrite_q;
  assign apbm_pwdata       = pwdata_q;

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// tb/tb_ahbl_to_apb_bridge.sv - self-checking bench for ahbl_to_apb_bridge with a transaction-level model.
// Honours APB_BRIDGE_SLVERR_EN the same way as the design.
module tb_ahbl_to_apb_bridge;

`ifdef APB_BRIDGE_SLVERR_EN
  localparam bit SLVERR = 1'b1;
`else
  localparam bit SLVERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_sync;
  logic        hready_resp, hresp, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, hrdata, pwdata, prdata;
  logic [15:0] paddr;
  logic        psel, penable, pwrite, pready, pslverr;

  int errors = 0;
  int checks = 0;

  bit [31:0]   slave_mem [int];
  bit [31:0]   ref_mem [int];
  logic [31:0] exp_hrdata, exp_pwdata;

  ahbl_to_apb_bridge dut (
    .clk               (clk),
    .rst_n_sync        (rst_n_sync),
    .ahbls_hready      (hready_resp),
    .ahbls_hready_resp (hready_resp),
    .ahbls_hresp       (hresp),
    .ahbls_haddr       (haddr),
    .ahbls_hwrite      (hwrite),
    .ahbls_htrans      (htrans),
    .ahbls_hsize       (hsize),
    .ahbls_hwdata      (hwdata),
    .ahbls_hrdata      (hrdata),
    .apbm_paddr        (paddr),
    .apbm_psel         (psel),
    .apbm_penable      (penable),
    .apbm_pwrite       (pwrite),
    .apbm_pwdata       (pwdata),
    .apbm_prdata       (prdata),
    .apbm_pready       (pready),
    .apbm_pslverr      (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  function automatic logic [31:0] slave_rd(input logic [15:0] a);
    return slave_mem.exists(int'(a)) ? slave_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      htrans  = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
      haddr   = $urandom;
      hwrite  = 1'($urandom_range(0, 1));
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_psel", psel, 0);
      chk("idle_hready_resp", hready_resp, 1);
      chk("idle_hresp", hresp, 0);
    end
    htrans = 2'b00;
  endtask

  // One AHB transfer; entered and left at a negedge where hready_resp is high,
  // so back-to-back calls present the next address in the response cycle.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input bit err);
    logic [15:0] pa;
    int lat, nsetup, naccess, nerr1, nwait;
    bit done, exp_err;
    pa = addr[15:0];
    exp_err = err && SLVERR;
    lat = 0; nsetup = 0; naccess = 0; nerr1 = 0; nwait = 0; done = 1'b0;
    haddr  = addr;
    hwrite = wr;
    htrans = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
    hsize  = 3'($urandom);
    hwdata = $urandom;
    @(negedge clk);
    lat = 1;
    htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom_range(0, 1)); hwdata = wd;
    while (!done && lat < 40) begin
      if (hready_resp) begin
        done = 1'b1;
      end else begin
        if (psel) begin
          chk("paddr", paddr, pa);
          chk("pwrite", pwrite, wr);
          if (wr) chk("pwdata", pwdata, wd);
          if (!penable) nsetup++;
          else begin
            naccess++;
            if (nwait < waits) begin
              pready = 1'b0; nwait++;
              pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
            end else begin
              pready = 1'b1; pslverr = err;
              prdata = wr ? $urandom : slave_rd(pa);
              if (wr && !err) slave_mem[int'(pa)] = pwdata;
            end
          end
        end else begin
          if (hresp) nerr1++;
          pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
        end
        @(negedge clk);
        lat++;
        if (lat == 2) hwdata = $urandom;
      end
    end
    if (!wr) exp_hrdata = ref_rd(pa);
    else begin
      exp_pwdata = wd;
      if (!err) ref_mem[int'(pa)] = wd;
    end
    chk("latency", lat, 3 + int'(wr) + waits + int'(exp_err));
    chk("setup_cycles", nsetup, 1);
    chk("access_cycles", naccess, waits + 1);
    chk("err1_cycles", nerr1, int'(exp_err));
    chk("resp_hresp", hresp, exp_err);
    chk("resp_psel", psel, 0);
    chk("hrdata", hrdata, exp_hrdata);
    chk("pwdata_hold", pwdata, exp_pwdata);
  endtask

  initial begin
    rst_n_sync = 1'b0;
    htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'b010; hwdata = '0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
    exp_hrdata = '0; exp_pwdata = '0;
    slave_mem[16'h0010] = 32'hDEADBEEF;
    ref_mem[16'h0010]   = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_hresp", hresp, 0);
    chk("rst_hready_resp", hready_resp, 1);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_hrdata", hrdata, 0);
    rst_n_sync = 1'b1;
    @(negedge clk);

    do_xfer(1'b0, 32'h4000_0010, 32'h0, 0, 1'b0);
    chk("t1_hrdata", hrdata, 32'hDEADBEEF);

    idle_cycles(10);

    do_xfer(1'b1, 32'h0000_0008, 32'h1234_5678, 3, 1'b0);
    chk("t2_pwdata", pwdata, 32'h1234_5678);

    do_xfer(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0);
    do_xfer(1'b1, 32'h0000_000C, 32'hCAFE_F00D, 0, 1'b0);
    idle_cycles(1);

    do_xfer(1'b0, 32'h0000_0018, 32'h0, 0, 1'b1);
    do_xfer(1'b1, 32'h0000_001C, 32'h5555_AAAA, 1, 1'b1);
    do_xfer(1'b0, 32'h0000_001C, 32'h0, 2, 1'b0);
    idle_cycles(2);

    for (int i = 0; i < 40; i++) begin
      do_xfer(1'($urandom_range(0, 1)),
              ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2),
              $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    haddr = 32'h0000_0014; hwrite = 1'b0; htrans = 2'b10;
    @(negedge clk);
    htrans = 2'b00; pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_access", {psel, penable}, 2'b11);
    #2 rst_n_sync = 1'b0;
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_hready_resp", hready_resp, 1);
    chk("rst_mid_hresp", hresp, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n_sync = 1'b1;
    exp_hrdata = '0; exp_pwdata = '0;
    pready = 1'b1;
    @(negedge clk);
    do_xfer(1'b0, 32'h4000_0010, 32'h0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
